// File: rtl/link_credit_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_credit_buffer_pkg
// Description : Shared sizing constants for the link credit buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package link_credit_buffer_pkg;

    localparam int FLIT_DATA_WIDTH = 8;
    localparam int LINK_BUF_DEPTH  = 4;

    // Counter must represent 0..depth inclusive, hence depth+1 states.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_credit_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : link_credit_buffer_if
// Description : Router-to-buffer flit link, sink handshake and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface link_credit_buffer_if
    import link_credit_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_DATA_WIDTH,
    parameter int DEPTH      = LINK_BUF_DEPTH
);
    localparam int CNT_BITS = cnt_bits(DEPTH);

    logic [FLIT_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [FLIT_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  credit_increment;
    logic [CNT_BITS-1:0]   occupancy;
    logic                  overflow_err;

    // Router/sink side drives flits and readiness.
    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, credit_increment, occupancy, overflow_err
    );

    // Buffer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, credit_increment, occupancy, overflow_err
    );

endinterface
`default_nettype wire

// File: rtl/link_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : link_credit_buffer
// Description : DEPTH-entry receive FIFO returning one credit per drained flit.
// Revision    : 1.0 - initial release
// ============================================================================
module link_credit_buffer
    import link_credit_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_DATA_WIDTH,
    parameter int DEPTH      = LINK_BUF_DEPTH
) (
    input  wire logic           clk,
    input  wire logic           reset,
    link_credit_buffer_if.slave bus
);

    localparam int CNT_BITS = cnt_bits(DEPTH);
    localparam int PTR_BITS = $clog2(DEPTH);

    localparam logic [CNT_BITS-1:0] c_full_cnt = CNT_BITS'(DEPTH);
    localparam logic [PTR_BITS-1:0] c_last_ptr = PTR_BITS'(DEPTH - 1);

    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [CNT_BITS-1:0]   r_occupancy;
    logic [CNT_BITS-1:0]   w_occupancy_nxt;
    logic                  r_credit;
    logic                  r_overflow;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_occupancy == '0);
    assign w_full  = (r_occupancy == c_full_cnt);
    assign w_pop   = !w_empty && bus.out_ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign w_push  = bus.in_valid && (!w_full || w_pop);

    always_comb begin
        w_occupancy_nxt = r_occupancy;
        case ({w_push, w_pop})
            2'b10:   w_occupancy_nxt = r_occupancy + 1'b1;
            2'b01:   w_occupancy_nxt = r_occupancy - 1'b1;
            default: w_occupancy_nxt = r_occupancy;
        endcase
    end

    // Storage is not reset; empty state masks it on out_data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occupancy <= '0;
            r_credit    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_occupancy <= w_occupancy_nxt;
            r_credit    <= w_pop;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (bus.in_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.out_data         = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.out_valid        = !w_empty;
    assign bus.credit_increment = r_credit;
    assign bus.occupancy        = r_occupancy;
    assign bus.overflow_err     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_link_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_credit_buffer
// Description : Directed vector bench for link_credit_buffer (DEPTH=4, 8-bit flits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_credit_buffer;

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [2:0] exp_occ;
        logic       exp_credit;
        logic       exp_err;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    link_credit_buffer_if #(.FLIT_WIDTH(8), .DEPTH(4)) bus ();

    link_credit_buffer #(.FLIT_WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                                input logic ev, input logic [7:0] ed, input logic [2:0] eo,
                                input logic ec, input logic ee);
        vec_t t;
        t.in_valid = v;  t.in_data = d;  t.out_ready = r;
        t.exp_valid = ev; t.exp_data = ed; t.exp_occ = eo;
        t.exp_credit = ec; t.exp_err = ee;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [7:0] ed,
                             input logic [2:0] eo, input logic ec, input logic ee);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, " out_data"}, 32'(bus.out_data), 32'(ed));
        check({tag, " occupancy"}, 32'(bus.occupancy), 32'(eo));
        check({tag, " credit"}, 32'(bus.credit_increment), 32'(ec));
        check({tag, " overflow_err"}, 32'(bus.overflow_err), 32'(ee));
    endtask

    // Apply inputs mid-cycle, then observe the state just after the next rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Fill, overflow, idle with junk data, drain, empty-ready, refill, full push+pop, drain across wrap.
        vecs.push_back(mk(1, 8'h0A, 0, 1, 8'h0A, 3'd1, 0, 0));
        vecs.push_back(mk(1, 8'h0B, 0, 1, 8'h0A, 3'd2, 0, 0));
        vecs.push_back(mk(1, 8'h0C, 0, 1, 8'h0A, 3'd3, 0, 0));
        vecs.push_back(mk(1, 8'h0D, 0, 1, 8'h0A, 3'd4, 0, 0));
        vecs.push_back(mk(1, 8'h0E, 0, 1, 8'h0A, 3'd4, 0, 1));
        vecs.push_back(mk(0, 8'hFF, 0, 1, 8'h0A, 3'd4, 0, 1));
        vecs.push_back(mk(0, 8'hFF, 1, 1, 8'h0B, 3'd3, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h0C, 3'd2, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h0D, 3'd1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 3'd0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 3'd0, 0, 1));
        vecs.push_back(mk(1, 8'h11, 0, 1, 8'h11, 3'd1, 0, 1));
        vecs.push_back(mk(1, 8'h12, 0, 1, 8'h11, 3'd2, 0, 1));
        vecs.push_back(mk(1, 8'h13, 0, 1, 8'h11, 3'd3, 0, 1));
        vecs.push_back(mk(1, 8'h14, 0, 1, 8'h11, 3'd4, 0, 1));
        vecs.push_back(mk(1, 8'h15, 1, 1, 8'h12, 3'd4, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h13, 3'd3, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h14, 3'd2, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 8'h15, 3'd1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 8'h00, 3'd0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 8'h00, 3'd0, 0, 1));

        foreach (vecs[i]) begin
            step(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                      vecs[i].exp_occ, vecs[i].exp_credit, vecs[i].exp_err);
        end

        // Reset mid-drain: asserted between edges with a pop pending; must clear at once.
        step(1, 8'h21, 0);
        step(1, 8'h22, 0);
        step(1, 8'h23, 0);
        check_all("pre_reset", 1'b1, 8'h21, 3'd3, 1'b0, 1'b1);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_reset1", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        step(0, 8'h00, 1);
        check_all("post_reset2", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Full with simultaneous push and pop from a clean error state.
        step(1, 8'h31, 0);
        step(1, 8'h32, 0);
        step(1, 8'h33, 0);
        step(1, 8'h34, 0);
        check_all("refill", 1'b1, 8'h31, 3'd4, 1'b0, 1'b0);
        step(1, 8'h35, 1);
        check_all("full_push_pop", 1'b1, 8'h32, 3'd4, 1'b1, 1'b0);
        step(0, 8'h00, 0);
        check_all("hold", 1'b1, 8'h32, 3'd4, 1'b0, 1'b0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        check_all("tail", 1'b1, 8'h35, 3'd1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
